emif_regbank_bridge: RTL and testbench

Synchronous slave bridge between the DSP asynchronous EMIF (16-bit, CS/WE/OE strobes) and FPGA logic. It replaces edge-clocked register capture with fully synchronised strobe sampling on one FPGA clock. It provides a parametrised control-register bank, a dual-port RAM window with an internal port B, an ID readback word, and EMIF wait-state generation during reads. It sits directly behind the top-level EMIF pins; the ema_d tristate buffer stays at top level.

---
 rtl/emif_pkg.sv | 39 +++
 rtl/emif_strobe_sync.sv | 39 +++
 rtl/emif_regbank_bridge.sv | 180 ++++++++++++++++++
 tb/tb_emif_regbank_bridge.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/emif_pkg.sv
// rtl/emif_pkg.sv - shared types and address decode for the EMIF register bank bridge
package emif_pkg;

  localparam int EMIF_ADDR_W = 8;
  localparam int EMIF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_HOLD  = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RD_DRIVE = 2'd3
  } emif_state_e;

  typedef enum logic [1:0] {
    RGN_REG = 2'd0,
    RGN_ID  = 2'd1,
    RGN_RAM = 2'd2
  } region_e;

  // Register window wins over the ID word; the window wraps modulo 2**aw.
  function automatic region_e decode_region(input int unsigned addr,
                                            input int unsigned base,
                                            input int unsigned num,
                                            input int unsigned id,
                                            input int unsigned aw);
    int unsigned mask;
    int unsigned off;
    mask = (32'd1 << aw) - 32'd1;
    off  = (addr - base) & mask;
    if (off < num) begin
      return RGN_REG;
    end else if ((addr & mask) == (id & mask)) begin
      return RGN_ID;
    end else begin
      return RGN_RAM;
    end
  endfunction

endpackage

// File: rtl/emif_strobe_sync.sv
// rtl/emif_strobe_sync.sv - two-flop synchronisers and falling-edge detect for EMIF strobes
module emif_strobe_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic cs_n_i,
  input  logic we_n_i,
  input  logic oe_n_i,
  output logic cs_n_o,
  output logic we_n_o,
  output logic oe_n_o,
  output logic we_fall_o,
  output logic oe_fall_o
);

  // bit order {oe, we, cs}; strobes idle high so flops reset to 1
  logic [2:0] s1_q;
  logic [2:0] s2_q;
  logic [1:0] s3_q;

  // metastability chain plus one extra stage on we/oe for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= 3'b111;
      s2_q <= 3'b111;
      s3_q <= 2'b11;
    end else begin
      s1_q <= {oe_n_i, we_n_i, cs_n_i};
      s2_q <= s1_q;
      s3_q <= s2_q[2:1];
    end
  end

  assign cs_n_o    = s2_q[0];
  assign we_n_o    = s2_q[1];
  assign oe_n_o    = s2_q[2];
  assign we_fall_o = s3_q[0] & ~s2_q[1];
  assign oe_fall_o = s3_q[1] & ~s2_q[2];

endmodule

// File: rtl/emif_regbank_bridge.sv
// rtl/emif_regbank_bridge.sv - synchronous EMIF slave with control registers, ID word and dual-port RAM
module emif_regbank_bridge
  import emif_pkg::*;
#(
  parameter int                ADDR_W     = EMIF_ADDR_W,
  parameter int                DATA_W     = EMIF_DATA_W,
  parameter int                NUM_REGS   = 4,
  parameter logic [ADDR_W-1:0] REG_BASE   = 8'h01,
  parameter logic [DATA_W-1:0] CTRL_RESET = 16'h55aa,
  parameter logic [ADDR_W-1:0] ID_ADDR    = 8'h04,
  parameter logic [DATA_W-1:0] ID_VALUE   = 16'haaaa
) (
  input  logic                       outclk_50mhz,
  input  logic                       rst_n,
  input  logic                       ema_cs_n,
  input  logic                       ema_we_n,
  input  logic                       ema_oe_n,
  input  logic [ADDR_W-1:0]          ema_addr,
  input  logic [DATA_W-1:0]          ema_d_in,
  output logic [DATA_W-1:0]          ema_d_out,
  output logic                       ema_d_oe,
  output logic                       ema_wait,
  output logic [NUM_REGS*DATA_W-1:0] ctrl_regs,
  output logic [NUM_REGS-1:0]        reg_wr_pulse,
  input  logic [ADDR_W-1:0]          b_addr,
  input  logic                       b_rd,
  input  logic                       b_wr,
  input  logic [DATA_W-1:0]          b_din,
  output logic [DATA_W-1:0]          b_dout,
  output logic                       b_valid,
  output logic                       proto_err
);

  logic cs_s, we_s, oe_s, we_fall, oe_fall;

  emif_strobe_sync u_sync (
    .clk_i     (outclk_50mhz),
    .rst_n_i   (rst_n),
    .cs_n_i    (ema_cs_n),
    .we_n_i    (ema_we_n),
    .oe_n_i    (ema_oe_n),
    .cs_n_o    (cs_s),
    .we_n_o    (we_s),
    .oe_n_o    (oe_s),
    .we_fall_o (we_fall),
    .oe_fall_o (oe_fall)
  );

  emif_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, rd_addr_q;
  logic [DATA_W-1:0]   data_q, d_out_q, rd_data;
  logic [DATA_W-1:0]   ctrl_q [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic                proto_q;
  logic [DATA_W-1:0]   b_dout_q;
  logic                b_valid_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];
  logic [DATA_W-1:0]   ram_a_q;

  logic              wr_start, rd_start, commit, a_we;
  region_e           wr_rgn, rd_rgn;
  logic [ADDR_W-1:0] wr_off, rd_off;

  // a write strobe takes precedence: a read only starts with we_n idle
  assign wr_start = (state_q == ST_IDLE) && !cs_s && we_fall;
  assign rd_start = (state_q == ST_IDLE) && !cs_s && oe_fall && we_s;
  assign commit   = (state_q == ST_WR_HOLD) && (we_s || cs_s);

  assign wr_rgn = decode_region(32'(addr_q), 32'(REG_BASE), NUM_REGS, 32'(ID_ADDR), ADDR_W);
  assign rd_rgn = decode_region(32'(rd_addr_q), 32'(REG_BASE), NUM_REGS, 32'(ID_ADDR), ADDR_W);
  assign wr_off = addr_q - REG_BASE;
  assign rd_off = rd_addr_q - REG_BASE;
  assign a_we   = commit && (wr_rgn == RGN_RAM);

  // transaction sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_start)      state_d = ST_WR_HOLD;
        else if (rd_start) state_d = ST_RD_WAIT;
      end
      ST_WR_HOLD:  if (commit)        state_d = ST_IDLE;
      ST_RD_WAIT:  state_d = cs_s ? ST_IDLE : ST_RD_DRIVE;
      ST_RD_DRIVE: if (oe_s || cs_s)  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // one-hot select of the register being committed
  always_comb begin
    pulse_d = '0;
    if (commit && (wr_rgn == RGN_REG)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_off == ADDR_W'(i)) pulse_d[i] = 1'b1;
      end
    end
  end

  // read mux, register window first, then ID, else RAM
  always_comb begin
    rd_data = ram_a_q;
    if (rd_rgn == RGN_ID) rd_data = ID_VALUE;
    if (rd_rgn == RGN_REG) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_off == ADDR_W'(i)) rd_data = ctrl_q[i];
      end
    end
  end

  // state, read address and bus data registers
  always_ff @(posedge outclk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      d_out_q   <= '0;
      proto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rd_start) rd_addr_q <= ema_addr;
      if ((state_q == ST_RD_WAIT) && !cs_s) d_out_q <= rd_data;
      if (!cs_s && !we_s && !oe_s) proto_q <= 1'b1;
    end
  end

  // track address/data while the synced write strobe is low; last value is committed
  always_ff @(posedge outclk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (!we_s && !cs_s) begin
      addr_q <= ema_addr;
      data_q <= ema_d_in;
    end
  end

  // control registers and their write strobes
  always_ff @(posedge outclk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) ctrl_q[i] <= CTRL_RESET;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (pulse_d[i]) ctrl_q[i] <= data_q;
      end
      pulse_q <= pulse_d;
    end
  end

  // RAM array: port A write listed last so it wins a same-address collision
  always_ff @(posedge outclk_50mhz) begin
    if (b_wr) mem[b_addr] <= b_din;
    if (a_we) mem[addr_q] <= data_q;
    if (rd_start) ram_a_q <= mem[ema_addr];
  end

  // port B read returns pre-write contents one cycle after the request
  always_ff @(posedge outclk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      b_dout_q  <= '0;
      b_valid_q <= 1'b0;
    end else begin
      b_valid_q <= b_rd;
      if (b_rd) b_dout_q <= mem[b_addr];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign ctrl_regs[g*DATA_W +: DATA_W] = ctrl_q[g];
  end

  assign ema_d_out    = d_out_q;
  assign ema_d_oe     = (state_q == ST_RD_DRIVE) && !oe_s && !cs_s;
  assign ema_wait     = (state_q == ST_RD_WAIT);
  assign reg_wr_pulse = pulse_q;
  assign b_dout       = b_dout_q;
  assign b_valid      = b_valid_q;
  assign proto_err    = proto_q;

endmodule

// File: tb/tb_emif_regbank_bridge.sv
// tb/tb_emif_regbank_bridge.sv - randomized self-checking bench against a behavioural model
module tb_emif_regbank_bridge;

  localparam int NR = 3;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst_n, cs_n, we_n, oe_n;
  logic [7:0]    ema_addr, b_addr;
  logic [15:0]   ema_d_in, ema_d_out, b_din, b_dout;
  logic          ema_d_oe, ema_wait, b_rd, b_wr, b_valid, proto_err;
  logic [NR*16-1:0] ctrl_regs;
  logic [NR-1:0] reg_wr_pulse;

  emif_regbank_bridge #(.NUM_REGS(NR)) dut (
    .outclk_50mhz (clk),
    .rst_n        (rst_n),
    .ema_cs_n     (cs_n),
    .ema_we_n     (we_n),
    .ema_oe_n     (oe_n),
    .ema_addr     (ema_addr),
    .ema_d_in     (ema_d_in),
    .ema_d_out    (ema_d_out),
    .ema_d_oe     (ema_d_oe),
    .ema_wait     (ema_wait),
    .ctrl_regs    (ctrl_regs),
    .reg_wr_pulse (reg_wr_pulse),
    .b_addr       (b_addr),
    .b_rd         (b_rd),
    .b_wr         (b_wr),
    .b_din        (b_din),
    .b_dout       (b_dout),
    .b_valid      (b_valid),
    .proto_err    (proto_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_ctrl [NR];
  logic [15:0] m_ram [256];
  logic [7:0]  known_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_reg(input logic [7:0] a);
    logic [7:0] off;
    off = a - 8'h01;
    return off < NR;
  endfunction

  function automatic logic [15:0] exp_read(input logic [7:0] a);
    logic [7:0] off;
    off = a - 8'h01;
    if (off < NR) return m_ctrl[off];
    if (a == 8'h04) return 16'haaaa;
    return m_ram[a];
  endfunction

  function automatic logic [NR*16-1:0] exp_ctrl();
    logic [NR*16-1:0] v;
    for (int i = 0; i < NR; i++) v[i*16 +: 16] = m_ctrl[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_ctrl[i] = 16'h55aa;
  endtask

  task automatic emif_write(input logic [7:0] a, input logic [15:0] d, input bit collide,
                            input logic [15:0] bd, input logic [15:0] b_old);
    int pulses;
    logic [NR-1:0] pv;
    logic [7:0] off;
    @(negedge clk); ema_addr = a; ema_d_in = d; cs_n = 1'b0;
    @(negedge clk); we_n = 1'b0;
    repeat (4) @(negedge clk);
    we_n = 1'b1;
    pulses = 0; pv = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (reg_wr_pulse != '0) begin pulses++; pv = reg_wr_pulse; end
      if (collide && i == 1) begin b_addr = a; b_din = bd; b_wr = 1'b1; b_rd = 1'b1; end
      if (collide && i == 2) begin
        chk("coll_b_valid", 64'(b_valid), 64'd1);
        chk("coll_b_old", 64'(b_dout), 64'(b_old));
        b_wr = 1'b0; b_rd = 1'b0;
      end
    end
    cs_n = 1'b1;
    off = a - 8'h01;
    if (is_reg(a)) begin
      m_ctrl[off] = d;
      chk($sformatf("wr_pulse_cnt_%h", a), 64'(pulses), 64'd1);
      chk($sformatf("wr_pulse_val_%h", a), 64'(pv), 64'(1 << off));
    end else begin
      if (a != 8'h04) begin m_ram[a] = d; known_q.push_back(a); end
      chk($sformatf("wr_no_pulse_%h", a), 64'(pulses), 64'd0);
    end
    chk("ctrl_regs", 64'(ctrl_regs), 64'(exp_ctrl()));
    repeat (2) @(negedge clk);
  endtask

  task automatic emif_read(input logic [7:0] a);
    int waits;
    bit done;
    @(negedge clk); ema_addr = a; cs_n = 1'b0;
    @(negedge clk); oe_n = 1'b0;
    waits = 0; done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (ema_d_oe) done = 1'b1;
      else if (ema_wait) waits++;
    end
    chk($sformatf("rd_drive_%h", a), 64'(done), 64'd1);
    chk($sformatf("rd_wait_cycles_%h", a), 64'(waits), 64'd1);
    chk("rd_wait_low_on_drive", 64'(ema_wait), 64'd0);
    chk($sformatf("rd_data_%h", a), 64'(ema_d_out), 64'(exp_read(a)));
    oe_n = 1'b1; cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rd_release", 64'(ema_d_oe), 64'd0);
  endtask

  task automatic b_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk); b_addr = a; b_din = d; b_wr = 1'b1;
    @(negedge clk); b_wr = 1'b0;
    m_ram[a] = d;
    known_q.push_back(a);
  endtask

  task automatic b_read(input logic [7:0] a);
    @(negedge clk); b_addr = a; b_rd = 1'b1;
    @(negedge clk); b_rd = 1'b0;
    chk($sformatf("b_valid_%h", a), 64'(b_valid), 64'd1);
    chk($sformatf("b_dout_%h", a), 64'(b_dout), 64'(m_ram[a]));
    @(negedge clk);
    chk("b_valid_drop", 64'(b_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int drv;
    logic [7:0] a;
    rst_n = 1'b0; cs_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    ema_addr = '0; ema_d_in = '0; b_addr = '0; b_rd = 1'b0; b_wr = 1'b0; b_din = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'(ctrl_regs), 64'(exp_ctrl()));
    chk("rst_d_out", 64'(ema_d_out), 64'd0);
    chk("rst_d_oe", 64'(ema_d_oe), 64'd0);
    chk("rst_wait", 64'(ema_wait), 64'd0);
    chk("rst_pulse", 64'(reg_wr_pulse), 64'd0);
    chk("rst_b_dout", 64'(b_dout), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_proto", 64'(proto_err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    emif_read(8'h01);
    emif_read(8'h04);
    emif_write(8'h02, 16'h1234, 1'b0, 16'h0, 16'h0);
    chk("reg1_slice", 64'(ctrl_regs[31:16]), 64'h1234);
    emif_read(8'h02);
    emif_write(8'h40, 16'hbeef, 1'b0, 16'h0, 16'h0);
    b_read(8'h40);
    b_write(8'h80, 16'hcafe);
    emif_read(8'h80);
    b_write(8'h81, 16'h0f0f);
    emif_write(8'h81, 16'h1111, 1'b1, 16'h2222, 16'h0f0f);
    emif_read(8'h81);
    b_read(8'h81);
    emif_write(8'h04, 16'hdead, 1'b0, 16'h0, 16'h0);
    emif_read(8'h04);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: emif_write(8'($urandom), 16'($urandom), 1'b0, 16'h0, 16'h0);
        1: begin
          case ($urandom_range(0, 2))
            0: a = 8'(1 + $urandom_range(0, NR - 1));
            1: a = 8'h04;
            default: a = known_q[$urandom_range(0, known_q.size() - 1)];
          endcase
          emif_read(a);
        end
        2: b_write(8'($urandom), 16'($urandom));
        default: b_read(known_q[$urandom_range(0, known_q.size() - 1)]);
      endcase
    end

    // reset while driving the bus
    @(negedge clk); ema_addr = 8'h02; cs_n = 1'b0;
    @(negedge clk); oe_n = 1'b0;
    for (int c = 0; c < 12 && !ema_d_oe; c++) @(negedge clk);
    chk("pre_rst_drive", 64'(ema_d_oe), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_d_oe", 64'(ema_d_oe), 64'd0);
    chk("mid_rst_wait", 64'(ema_wait), 64'd0);
    chk("mid_rst_ctrl", 64'(ctrl_regs), 64'(exp_ctrl()));
    oe_n = 1'b1; cs_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    emif_read(8'h02);

    // simultaneous write and read strobes
    @(negedge clk); ema_addr = 8'h90; ema_d_in = 16'h7777; cs_n = 1'b0;
    @(negedge clk); we_n = 1'b0; oe_n = 1'b0;
    drv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ema_d_oe || ema_wait) drv++;
    end
    chk("proto_set", 64'(proto_err), 64'd1);
    we_n = 1'b1; oe_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ema_d_oe || ema_wait) drv++;
    end
    cs_n = 1'b1;
    chk("proto_no_read", 64'(drv), 64'd0);
    m_ram[8'h90] = 16'h7777;
    repeat (2) @(negedge clk);
    emif_read(8'h90);
    chk("proto_sticky", 64'(proto_err), 64'd1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("proto_cleared", 64'(proto_err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
